// File: rtl/checker_pkg.sv
// checker_pkg: shared state, policy encodings and defaults for the checker read sequencer
package checker_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;
  localparam logic [1:0] MODE_POLL = 2'b00;
  localparam logic [1:0] MODE_IRQ_END = 2'b01;
  localparam logic [1:0] MODE_IRQ_ALL = 2'b10;
  localparam int PAGE_BITS_DEF = 12;
  function automatic logic irq_wanted(input logic [1:0] m, input logic err);
    return (m == MODE_IRQ_END && !err) || m == MODE_IRQ_ALL;
  endfunction
endpackage

// File: rtl/checker_read.sv
// checker_read: sequences a mode-side read request into a page-aligned hm fetch and reports the result
// Ports:
//   sys_clk, sys_rst         clock, async active-low reset
//   mode_mode/start/addr/ack request policy, level request, byte address, irq acknowledge
//   mode_end/error/irq/data  completion flags, interrupt, measured latency in cycles
//   hm_page_addr/hm_start    page-aligned fetch address and one-cycle fetch pulse
//   hm_end/timeout/error     fetch result pulses
// Optional: CHECKER_READ_WATCHDOG_EN ends WAIT with an error after WDOG_CYCLES silent cycles.
// Latency is the number of cycles from the hm_start cycle to the response cycle, so a response
// in the cycle right after hm_start reports 1.
module checker_read
  import checker_pkg::*;
#(
  parameter int PAGE_BITS = PAGE_BITS_DEF,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  mode_mode,
  input  logic        mode_start,
  input  logic [63:0] mode_addr,
  output logic        mode_end,
  output logic [63:0] mode_data,
  output logic        mode_irq,
  input  logic        mode_ack,
  output logic        mode_error,
  output logic [63:0] hm_page_addr,
  output logic        hm_start,
  input  logic        hm_end,
  input  logic        hm_timeout,
  input  logic        hm_error
);
  localparam logic [63:0] PAGE_MASK = ~((64'd1 << PAGE_BITS) - 64'd1);
  state_e state_q;
  logic err_q, irq_q, hm_start_q;
  logic [1:0] pol_q;
  logic [63:0] cnt_q, cnt_d, data_q, addr_q;
  logic wdog_hit, fail, resp;
  assign cnt_d = &cnt_q ? cnt_q : cnt_q + 64'd1;
`ifdef CHECKER_READ_WATCHDOG_EN
  assign wdog_hit = cnt_d == 64'(WDOG_CYCLES);
`else
  logic unused_wdog;
  assign wdog_hit = 1'b0;
  assign unused_wdog = ^WDOG_CYCLES;
`endif
  assign fail = hm_timeout | hm_error | wdog_hit;
  assign resp = hm_end | fail;
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      err_q <= 1'b0;
      irq_q <= 1'b0;
      hm_start_q <= 1'b0;
      pol_q <= MODE_POLL;
      cnt_q <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      hm_start_q <= 1'b0;
      // a set later in this block overrides the ack
      if (mode_ack) irq_q <= 1'b0;
      case (state_q)
        IDLE: if (mode_start) begin
          addr_q <= mode_addr & PAGE_MASK;
          pol_q <= mode_mode;
          cnt_q <= '0;
          hm_start_q <= 1'b1;
          state_q <= START;
        end
        START: state_q <= WAIT;
        WAIT: if (!mode_start) state_q <= IDLE;
        else begin
          cnt_q <= cnt_d;
          if (resp) begin
            data_q <= cnt_d;
            err_q <= fail;
            state_q <= DONE;
            if (irq_wanted(pol_q, fail)) irq_q <= 1'b1;
          end
        end
        default: if (!mode_start) state_q <= IDLE;
      endcase
    end
  end
  assign mode_end = state_q == DONE && !err_q;
  assign mode_error = state_q == DONE && err_q;
  assign mode_irq = irq_q;
  assign mode_data = data_q;
  assign hm_page_addr = addr_q;
  assign hm_start = hm_start_q;
endmodule

// File: tb/tb_checker_read.sv
module tb_checker_read;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic [1:0] mode_mode = 2'b00;
  logic mode_start = 1'b0;
  logic [63:0] mode_addr = '0;
  logic mode_ack = 1'b0;
  logic hm_end = 1'b0, hm_timeout = 1'b0, hm_error = 1'b0;
  logic mode_end, mode_irq, mode_error, hm_start;
  logic [63:0] mode_data, hm_page_addr;
  int checks = 0;
  int errors = 0;
  logic irq_exp = 1'b0;
  logic [63:0] data_exp = '0;
`ifdef CHECKER_READ_WATCHDOG_EN
  localparam int MAXD = 12;
`else
  localparam int MAXD = 40;
`endif
  localparam int D20 = MAXD < 20 ? MAXD : 20;

  checker_read #(.PAGE_BITS(12), .WDOG_CYCLES(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_mode(mode_mode), .mode_start(mode_start),
    .mode_addr(mode_addr), .mode_end(mode_end), .mode_data(mode_data), .mode_irq(mode_irq),
    .mode_ack(mode_ack), .mode_error(mode_error), .hm_page_addr(hm_page_addr),
    .hm_start(hm_start), .hm_end(hm_end), .hm_timeout(hm_timeout), .hm_error(hm_error)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(negedge sys_clk);
  endtask

  task automatic test_reset;
    sys_rst = 1'b0;
    repeat (2) tick;
    checks++;
    if ({mode_end, mode_error, mode_irq, hm_start, mode_data, hm_page_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got end=%b err=%b irq=%b hs=%b data=%h pa=%h, expected all zero",
               mode_end, mode_error, mode_irq, hm_start, mode_data, hm_page_addr);
    end
    sys_rst = 1'b1;
    tick;
  endtask

  // kind: 0 end, 1 timeout, 2 error, 3 end together with error
  task automatic test_request(input logic [1:0] mode, input logic [63:0] addr, input int d,
                              input int kind, input logic ack_at_set, input int hold,
                              input logic do_ack);
    logic [63:0] page;
    logic err, want;
    page = addr - (addr % 64'd4096);
    err = kind != 0;
    want = (mode == 2'd1 && !err) || mode == 2'd2;
    mode_mode = mode;
    mode_addr = addr;
    mode_start = 1'b1;
    tick;
    checks++;
    if (hm_start !== 1'b1) begin
      errors++;
      $display("FAIL hm_start_pulse: got %b expected 1", hm_start);
    end
    checks++;
    if (hm_page_addr !== page) begin
      errors++;
      $display("FAIL page_addr: got %h expected %h", hm_page_addr, page);
    end
    mode_addr = {$urandom, $urandom};
    tick;
    checks++;
    if (hm_start !== 1'b0) begin
      errors++;
      $display("FAIL hm_start_one_cycle: got %b expected 0", hm_start);
    end
    repeat (d - 1) tick;
    hm_end = kind == 0 || kind == 3;
    hm_timeout = kind == 1;
    hm_error = kind >= 2;
    mode_ack = ack_at_set;
    tick;
    {hm_end, hm_timeout, hm_error, mode_ack} = '0;
    data_exp = 64'(d);
    irq_exp = want ? 1'b1 : (ack_at_set ? 1'b0 : irq_exp);
    checks++;
    if ({mode_end, mode_error} !== {!err, err}) begin
      errors++;
      $display("FAIL done_flags: got end=%b err=%b expected end=%b err=%b", mode_end, mode_error, !err, err);
    end
    checks++;
    if (mode_data !== data_exp) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d", mode_data, data_exp);
    end
    checks++;
    if (mode_irq !== irq_exp) begin
      errors++;
      $display("FAIL irq_at_done: got %b expected %b", mode_irq, irq_exp);
    end
    checks++;
    if (hm_page_addr !== page) begin
      errors++;
      $display("FAIL page_addr_stable: got %h expected %h", hm_page_addr, page);
    end
    repeat (hold) tick;
    checks++;
    if ({mode_end, mode_error} !== {!err, err}) begin
      errors++;
      $display("FAIL done_held: got end=%b err=%b expected end=%b err=%b", mode_end, mode_error, !err, err);
    end
    mode_start = 1'b0;
    tick;
    checks++;
    if ({mode_end, mode_error, mode_irq} !== {2'b00, irq_exp}) begin
      errors++;
      $display("FAIL after_drop: got end=%b err=%b irq=%b expected 0 0 %b", mode_end, mode_error, mode_irq, irq_exp);
    end
    if (do_ack) begin
      mode_ack = 1'b1;
      tick;
      mode_ack = 1'b0;
      irq_exp = 1'b0;
      checks++;
      if (mode_irq !== 1'b0) begin
        errors++;
        $display("FAIL irq_ack: got %b expected 0", mode_irq);
      end
    end
  endtask

  task automatic test_abort(input int d);
    mode_mode = 2'd2;
    mode_addr = 64'h1000;
    mode_start = 1'b1;
    tick;
    repeat (d) tick;
    mode_start = 1'b0;
    tick;
    checks++;
    if ({mode_end, mode_error, mode_irq, mode_data} !== {2'b00, irq_exp, data_exp}) begin
      errors++;
      $display("FAIL abort: got end=%b err=%b irq=%b data=%0d expected 0 0 %b %0d",
               mode_end, mode_error, mode_irq, mode_data, irq_exp, data_exp);
    end
    hm_end = 1'b1;
    tick;
    hm_end = 1'b0;
    tick;
    checks++;
    if ({mode_end, mode_error, mode_irq, hm_start, mode_data} !== {3'b000, irq_exp, data_exp}) begin
      errors++;
      $display("FAIL late_hm_end: got end=%b err=%b hs=%b irq=%b data=%0d expected 0 0 0 %b %0d",
               mode_end, mode_error, hm_start, mode_irq, mode_data, irq_exp, data_exp);
    end
  endtask

  task automatic test_reset_mid_wait;
    mode_mode = 2'd1;
    mode_addr = 64'h5000;
    mode_start = 1'b1;
    repeat (6) tick;
    sys_rst = 1'b0;
    #1;
    checks++;
    if ({mode_end, mode_error, mode_irq, hm_start, mode_data, hm_page_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: got end=%b err=%b irq=%b hs=%b data=%h pa=%h expected all zero",
               mode_end, mode_error, mode_irq, hm_start, mode_data, hm_page_addr);
    end
    mode_start = 1'b0;
    tick;
    sys_rst = 1'b1;
    irq_exp = 1'b0;
    data_exp = '0;
    hm_end = 1'b1;
    tick;
    hm_end = 1'b0;
    tick;
    checks++;
    if ({mode_end, mode_error, mode_irq, hm_start, mode_data} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: outputs not all zero (end=%b err=%b irq=%b hs=%b data=%h)",
               mode_end, mode_error, mode_irq, hm_start, mode_data);
    end
  endtask

`ifdef CHECKER_READ_WATCHDOG_EN
  task automatic test_watchdog;
    int n = 0;
    mode_mode = 2'd2;
    mode_addr = 64'h2000;
    mode_start = 1'b1;
    tick;
    while (mode_error !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    data_exp = 64'd16;
    irq_exp = 1'b1;
    checks++;
    if ({mode_error, mode_end, mode_irq, mode_data} !== {3'b101, data_exp}) begin
      errors++;
      $display("FAIL watchdog: got err=%b end=%b irq=%b data=%0d after %0d cycles expected 1 0 1 16",
               mode_error, mode_end, mode_irq, mode_data, n);
    end
    mode_start = 1'b0;
    mode_ack = 1'b1;
    tick;
    mode_ack = 1'b0;
    irq_exp = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_request(2'd0, 64'h1000, D20, 0, 1'b0, 2, 1'b0);
    test_abort(D20);
    test_request(2'd2, 64'h1000, D20, 2, 1'b0, 1, 1'b1);
    test_request(2'd1, 64'h1234, D20, 1, 1'b0, 0, 1'b0);
    test_request(2'd1, 64'hFFFF_FFFF_FFFF_FABC, 1, 0, 1'b0, 0, 1'b0);
    test_request(2'd2, 64'h7777_0000_0000_0FFF, 3, 3, 1'b1, 1, 1'b1);
    test_request(2'd3, 64'h0000_0000_0000_2FFF, 5, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 12; i++)
      test_request(2'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(1, MAXD),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
    test_reset_mid_wait;
`ifdef CHECKER_READ_WATCHDOG_EN
    test_watchdog;
`endif
    test_request(2'd1, 64'hABCD_1234, 7, 0, 1'b0, 1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
